serial_add_sched: RTL and testbench

SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

---
 rtl/serial_add_sched_if.sv | 34 +++
 rtl/serial_add_sched.sv | 109 ++++++++++
 tb/tb_serial_add_sched.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/serial_add_sched_if.sv
// rtl/serial_add_sched_if.sv - request/result bundle for the bit-serial adder scheduler
interface serial_add_sched_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             ack0;
  logic             ack1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ser_valid;
  logic             ser_a;
  logic             ser_b;
  logic             ser_sum;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  ack0, ack1, busy, done, done_id, sum, cout,
           ser_valid, ser_a, ser_b, ser_sum
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output ack0, ack1, busy, done, done_id, sum, cout,
           ser_valid, ser_a, ser_b, ser_sum
  );
endinterface

// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - two-requester round-robin scheduler around a bit-serial adder
module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  serial_add_sched_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic             last_grant;
  logic             cur_id;
  logic             ack0_r, ack1_r, busy_r, done_r, done_id_r, cout_r, ser_valid_r;
  logic [WIDTH-1:0] sum_r;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] sum_next;
  logic             pick1;

  assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign sum_next = {s_bit, sum_sh};
  // On a tie requester 1 wins only if requester 0 was granted last.
  assign pick1    = bus.req1 & (~bus.req0 | ~last_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      last_grant  <= 1'b1;
      cur_id      <= 1'b0;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      done_id_r   <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ser_valid_r <= 1'b0;
    end else begin
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            cur_id      <= pick1;
            last_grant  <= pick1;
            a_sh        <= pick1 ? bus.a1 : bus.a0;
            b_sh        <= pick1 ? bus.b1 : bus.b0;
            carry       <= 1'b0;
            cnt         <= '0;
            ack0_r      <= ~pick1;
            ack1_r      <= pick1;
            busy_r      <= 1'b1;
            ser_valid_r <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= c_next;
          sum_sh <= sum_next[WIDTH-1:1];
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum_r       <= sum_next;
            cout_r      <= c_next;
            done_id_r   <= cur_id;
            done_r      <= 1'b1;
            ser_valid_r <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack0      = ack0_r;
  assign bus.ack1      = ack1_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.done_id   = done_id_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ser_valid = ser_valid_r;
  assign bus.ser_a     = ser_valid_r & a_sh[0];
  assign bus.ser_b     = ser_valid_r & b_sh[0];
  assign bus.ser_sum   = ser_valid_r & s_bit;
endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - randomized self-checking bench for serial_add_sched
module tb_serial_add_sched;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_add_sched_if #(.WIDTH(W)) bus();
  serial_add_sched #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int last_grant = 1;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {bus.ack0, bus.ack1, bus.busy, bus.done, bus.done_id, bus.sum, bus.cout,
              bus.ser_valid, bus.ser_a, bus.ser_b, bus.ser_sum}, '0);
  endtask

  // Raises the given requests, waits for the grant the round-robin rule predicts,
  // then checks every serial slice and the final result against plain arithmetic.
  task automatic serve(input logic [W-1:0] a0, b0, a1, b1, input logic q0, q1,
                       input bit drop, input bit toggle, output int waited, output int ack_cyc);
    logic g;
    logic [W-1:0] ea, eb;
    logic [W:0] r;
    g  = (q0 && q1) ? (last_grant == 0) : q1;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    r  = {1'b0, ea} + {1'b0, eb};
    bus.a0 = a0; bus.b0 = b0; bus.a1 = a1; bus.b1 = b1;
    bus.req0 = q0; bus.req1 = q1;
    waited = 0;
    do begin
      step();
      waited++;
      if (!(bus.ack0 | bus.ack1)) chk("idle_busy", {bus.busy, bus.done}, 2'b00);
    end while (!(bus.ack0 | bus.ack1) && waited < 6);
    ack_cyc = cyc;
    last_grant = int'(g);
    if (drop) begin
      if (g) bus.req1 = 1'b0;
      else   bus.req0 = 1'b0;
    end
    for (int k = 0; k < W; k++) begin
      if (k > 0) step();
      chk($sformatf("run_bit%0d", k),
          {bus.ser_valid, bus.ser_a, bus.ser_b, bus.ser_sum, bus.busy, bus.done, bus.ack0, bus.ack1},
          {1'b1, ea[k], eb[k], r[k], 1'b1, 1'b0, (k == 0) && !g, (k == 0) && g});
      if (toggle) begin
        bus.req0 = 1'($urandom);
        bus.req1 = 1'($urandom);
      end
    end
    step();
    chk("done_flags", {bus.done, bus.busy, bus.ser_valid, bus.ack0, bus.ack1, bus.done_id},
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, g});
    chk("sum", bus.sum, r[W-1:0]);
    chk("cout", bus.cout, r[W]);
    chk("latency", cyc - ack_cyc, W);
    if (toggle) begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end
  endtask

  initial begin
    int w, t0, t1, n;
    logic [W-1:0] ra0, rb0, ra1, rb1;
    logic q0, q1;
    reset = 1'b1;
    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
    step(); step();
    chk_all_zero("reset_state");
    reset = 1'b0;
    step();

    serve(8'h05, 8'h03, 8'h00, 8'h00, 1, 0, 1, 0, w, t0);
    step();
    chk("after_done", {bus.done, bus.busy}, 2'b00);
    step(); step();
    chk("sum_hold", {bus.cout, bus.done_id, bus.sum}, {1'b0, 1'b0, 8'h08});

    serve(8'h00, 8'h00, 8'hFF, 8'h01, 0, 1, 1, 0, w, t0);

    reset = 1'b1; step(); reset = 1'b0; last_grant = 1;
    serve(8'h11, 8'h22, 8'h33, 8'h44, 1, 1, 1, 0, w, t0);
    chk("tie_first_is_0", last_grant, 0);
    serve(8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 1, 0, w, t1);
    chk("tie_ack_spacing", t1 - t0, W + 2);
    chk("tie_wait", w, 2);
    bus.req0 = 0; bus.req1 = 0;
    step(); step();

    t0 = -1;
    for (int i = 0; i < 4; i++) begin
      serve(8'h3C, 8'h5A, 8'hC3, 8'h99, 1, 1, 0, 0, w, t1);
      chk($sformatf("alt_grant%0d", i), last_grant, i % 2);
      if (i > 0) begin
        chk("alt_spacing", t1 - t0, W + 2);
        chk("alt_gap", w, 2);
      end
      t0 = t1;
    end
    bus.req0 = 0; bus.req1 = 0;
    step(); step();

    bus.a0 = 8'hAA; bus.b0 = 8'h55; bus.req0 = 1;
    n = 0;
    do begin step(); n++; end while (!bus.ack0 && n < 6);
    chk("abort_ack", bus.ack0, 1'b1);
    bus.req0 = 0;
    for (int k = 0; k < 4; k++) step();
    reset = 1'b1;
    #1;
    chk_all_zero("abort_reset");
    step();
    reset = 1'b0;
    last_grant = 1;
    n = 0;
    for (int k = 0; k < W + 4; k++) begin
      step();
      if (bus.done) n++;
    end
    chk("abort_no_done", n, 0);
    serve(8'hAA, 8'h55, 8'h00, 8'h00, 1, 0, 1, 0, w, t0);

    serve(8'h7E, 8'h13, 8'h00, 8'h00, 1, 0, 1, 1, w, t0);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.ack0 | bus.ack1) n++;
    end
    chk("toggle_no_extra_ack", n, 0);

    for (int i = 0; i < 20; i++) begin
      ra0 = W'($urandom); rb0 = W'($urandom);
      ra1 = W'($urandom); rb1 = W'($urandom);
      q0 = 1'($urandom); q1 = 1'($urandom);
      if (!q0 && !q1) q0 = 1'b1;
      serve(ra0, rb0, ra1, rb1, q0, q1, 1, 0, w, t0);
      if ($urandom_range(0, 1) == 1) begin
        bus.req0 = 0; bus.req1 = 0;
        step();
      end
    end
    bus.req0 = 0; bus.req1 = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
